// File: rtl/dpa_trigger_periph_if.sv
// Peripheral bus bundle for the DPA trigger block: word address, write data,
// byte enables and the ORed read-data return.
interface dpa_trigger_periph_if;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;

  modport master (output per_addr, per_din, per_en, per_we, input per_dout);
  modport slave  (input per_addr, per_din, per_en, per_we, output per_dout);
endinterface

// File: rtl/dpa_trigger_periph.sv
// Scope-trigger peripheral: software or external-pin start, programmable delay,
// then a fixed-width trig_out pulse; DONE/OVR status, pulse counter and an IRQ.
module dpa_trigger_periph #(
  parameter logic [13:0] BASE_ADDR = 14'h00C8
) (
  input  logic                 mclk,
  input  logic                 puc_rst,
  dpa_trigger_periph_if.slave  bus,
  input  logic                 gpio_in,
  output logic                 trig_out,
  output logic                 irq_trig
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_PULSE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [15:0] width_lat, width_lat_nxt;
  logic        ie, ext_en, done, ovr;
  logic [15:0] delay_reg, width_reg, pcount;
  logic        gpio_s1, gpio_sync, gpio_sync_d;

  // Bus decode
  logic       sel, wr_lo, wr_hi, wr_any, rd;
  logic [2:0] reg_off;

  assign sel     = bus.per_en && (bus.per_addr[13:3] == BASE_ADDR[13:3]);
  assign reg_off = bus.per_addr[2:0];
  assign wr_lo   = sel && bus.per_we[0];
  assign wr_hi   = sel && bus.per_we[1];
  assign wr_any  = wr_lo || wr_hi;
  assign rd      = sel && (bus.per_we == 2'b00);

  logic ctrl_wr, start_wr, abort, rise, start_evt, busy, ovr_set, pulse_done;
  logic [15:0] width_eff;

  assign ctrl_wr   = wr_lo && (reg_off == 3'd0);
  assign start_wr  = ctrl_wr && bus.per_din[2];
  assign abort     = ctrl_wr && bus.per_din[3];
  assign rise      = gpio_sync && !gpio_sync_d;
  assign start_evt = start_wr || (ext_en && rise);
  assign busy      = (state != ST_IDLE);
  assign ovr_set   = start_evt && busy;
  // A zero WIDTH still yields a one-cycle pulse
  assign width_eff = (width_reg == 16'd0) ? 16'd1 : width_reg;

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    width_lat_nxt = width_lat;
    pulse_done    = 1'b0;
    if (abort) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = 16'd0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start_evt) begin
            // Width is captured at start so later WIDTH writes cannot alter this pulse
            width_lat_nxt = width_eff;
            if (delay_reg != 16'd0) begin
              state_nxt = ST_DELAY;
              cnt_nxt   = delay_reg;
            end else begin
              state_nxt = ST_PULSE;
              cnt_nxt   = width_eff;
            end
          end
        end
        ST_DELAY: begin
          if (cnt <= 16'd1) begin
            state_nxt = ST_PULSE;
            cnt_nxt   = width_lat;
          end else begin
            cnt_nxt = cnt - 16'd1;
          end
        end
        ST_PULSE: begin
          if (cnt <= 16'd1) begin
            state_nxt  = ST_IDLE;
            cnt_nxt    = 16'd0;
            pulse_done = 1'b1;
          end else begin
            cnt_nxt = cnt - 16'd1;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = 16'd0;
        end
      endcase
    end
  end

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state     <= ST_IDLE;
      cnt       <= 16'd0;
      width_lat <= 16'd0;
      trig_out  <= 1'b0;
      irq_trig  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      width_lat <= width_lat_nxt;
      trig_out  <= (state_nxt == ST_PULSE);
      irq_trig  <= ie && done;
    end
  end

  // Register file and status
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      ie        <= 1'b0;
      ext_en    <= 1'b0;
      delay_reg <= 16'd0;
      width_reg <= 16'd0;
      done      <= 1'b0;
      ovr       <= 1'b0;
      pcount    <= 16'd0;
    end else begin
      if (ctrl_wr) begin
        ie     <= bus.per_din[0];
        ext_en <= bus.per_din[1];
      end
      if (wr_lo && reg_off == 3'd1) delay_reg[7:0]  <= bus.per_din[7:0];
      if (wr_hi && reg_off == 3'd1) delay_reg[15:8] <= bus.per_din[15:8];
      if (wr_lo && reg_off == 3'd2) width_reg[7:0]  <= bus.per_din[7:0];
      if (wr_hi && reg_off == 3'd2) width_reg[15:8] <= bus.per_din[15:8];

      // Set has priority over write-1-to-clear
      if (pulse_done)
        done <= 1'b1;
      else if (wr_lo && reg_off == 3'd3 && bus.per_din[1])
        done <= 1'b0;

      if (ovr_set)
        ovr <= 1'b1;
      else if (wr_lo && reg_off == 3'd3 && bus.per_din[2])
        ovr <= 1'b0;

      if (wr_any && reg_off == 3'd4)
        pcount <= 16'd0;
      else if (pulse_done)
        pcount <= pcount + 16'd1;
    end
  end

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      gpio_s1     <= 1'b0;
      gpio_sync   <= 1'b0;
      gpio_sync_d <= 1'b0;
    end else begin
      gpio_s1     <= gpio_in;
      gpio_sync   <= gpio_s1;
      gpio_sync_d <= gpio_sync;
    end
  end

  // Read mux; zero when not selected so it can be ORed onto the shared bus
  always_comb begin
    bus.per_dout = 16'h0000;
    if (rd) begin
      unique case (reg_off)
        3'd0:    bus.per_dout = {14'd0, ext_en, ie};
        3'd1:    bus.per_dout = delay_reg;
        3'd2:    bus.per_dout = width_reg;
        3'd3:    bus.per_dout = {10'd0, 2'(state), gpio_sync, ovr, done, busy};
        3'd4:    bus.per_dout = pcount;
        default: bus.per_dout = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_dpa_trigger_periph.sv
// Directed bench for dpa_trigger_periph: expected values are queued as stimulus
// is applied and popped when the corresponding DUT output is sampled.
module tb_dpa_trigger_periph;
  localparam logic [13:0] BASE = 14'h00C8;

  logic mclk = 1'b0;
  logic puc_rst, gpio_in, trig_out, irq_trig;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] exp_q[$];

  dpa_trigger_periph_if bus();

  dpa_trigger_periph #(.BASE_ADDR(BASE)) dut (
    .mclk     (mclk),
    .puc_rst  (puc_rst),
    .bus      (bus),
    .gpio_in  (gpio_in),
    .trig_out (trig_out),
    .irq_trig (irq_trig)
  );

  always #5 mclk = ~mclk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge mclk);
  endtask

  task automatic wr(input logic [2:0] off, input logic [15:0] d, input logic [1:0] we);
    bus.per_addr = BASE + 14'(off);
    bus.per_din  = d;
    bus.per_en   = 1'b1;
    bus.per_we   = we;
    tick();
    bus.per_en   = 1'b0;
    bus.per_we   = 2'b00;
    bus.per_din  = 16'h0000;
  endtask

  task automatic rd_addr(input string tag, input logic [13:0] addr, input logic [15:0] exp);
    exp_q.push_back(exp);
    bus.per_addr = addr;
    bus.per_en   = 1'b1;
    bus.per_we   = 2'b00;
    #1;
    chk(tag, bus.per_dout, exp_q.pop_front());
    bus.per_en   = 1'b0;
    #1;
  endtask

  task automatic rd(input string tag, input logic [2:0] off, input logic [15:0] exp);
    rd_addr(tag, BASE + 14'(off), exp);
  endtask

  // Bit i of each pattern applies to the i-th sampled cycle; gpio_in is driven
  // after the sample so it is captured at the end of that cycle.
  task automatic run(input string tag, input int n, input logic [127:0] tp,
                     input logic [127:0] ip, input logic [127:0] gp);
    for (int i = 0; i < n; i++) exp_q.push_back({15'd0, tp[i]});
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_trig[%0d]", tag, i), {15'd0, trig_out}, exp_q.pop_front());
      chk($sformatf("%s_irq[%0d]", tag, i), {15'd0, irq_trig}, {15'd0, ip[i]});
      gpio_in = gp[i];
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    puc_rst      = 1'b1;
    gpio_in      = 1'b0;
    bus.per_addr = 14'd0;
    bus.per_din  = 16'd0;
    bus.per_en   = 1'b0;
    bus.per_we   = 2'b00;
    repeat (3) tick();
    puc_rst = 1'b0;

    // Reset state
    chk("rst_trig", {15'd0, trig_out}, 16'd0);
    chk("rst_irq",  {15'd0, irq_trig}, 16'd0);
    for (int o = 0; o < 5; o++) rd($sformatf("rst_reg%0d", o), 3'(o), 16'h0000);

    // DELAY=3 WIDTH=2: pulse in t+4, t+5
    wr(3'd1, 16'd3, 2'b11);
    wr(3'd2, 16'd2, 2'b11);
    wr(3'd0, 16'h0004, 2'b01);
    run("d3w2", 6, 128'b011000, 128'b0, 128'b0);
    rd("d3w2_status", 3'd3, 16'h0002);
    rd("d3w2_pcount", 3'd4, 16'd1);
    wr(3'd3, 16'h0002, 2'b01);
    rd("d3w2_clr", 3'd3, 16'h0000);

    // DELAY=0 WIDTH=0 with IE: one-cycle pulse, irq two cycles later
    wr(3'd1, 16'd0, 2'b11);
    wr(3'd2, 16'd0, 2'b11);
    wr(3'd0, 16'h0005, 2'b01);
    run("d0w0", 4, 128'b0001, 128'b1100, 128'b0);
    wr(3'd3, 16'h0002, 2'b01);
    rd("d0w0_status", 3'd3, 16'h0000);
    run("d0w0_clr", 2, 128'b0, 128'b01, 128'b0);
    rd("d0w0_pcount", 3'd4, 16'd2);
    wr(3'd0, 16'h0000, 2'b01);

    // External trigger, WIDTH=4, second edge mid-pulse sets OVR
    wr(3'd2, 16'd4, 2'b11);
    wr(3'd0, 16'h0002, 2'b01);
    gpio_in = 1'b1;
    tick();
    run("ext", 8, 128'b00111100, 128'b0, 128'b11111100);
    rd("ext_status", 3'd3, 16'h000E);
    rd("ext_pcount", 3'd4, 16'd3);
    gpio_in = 1'b0;
    wr(3'd0, 16'h0000, 2'b01);
    wr(3'd3, 16'h0006, 2'b01);
    repeat (3) tick();
    rd("ext_clr", 3'd3, 16'h0000);

    // WIDTH write while busy does not change the pulse in flight
    wr(3'd1, 16'd2, 2'b11);
    wr(3'd2, 16'd2, 2'b11);
    wr(3'd0, 16'h0004, 2'b01);
    wr(3'd2, 16'd8, 2'b11);
    run("busywr", 5, 128'b00110, 128'b0, 128'b0);
    rd("busywr_pcount", 3'd4, 16'd4);
    wr(3'd3, 16'h0002, 2'b01);

    // ABORT during a long delay
    wr(3'd1, 16'd100, 2'b11);
    wr(3'd0, 16'h0004, 2'b01);
    run("abort_pre", 9, 128'b0, 128'b0, 128'b0);
    wr(3'd0, 16'h0008, 2'b01);
    run("abort_post", 110, 128'b0, 128'b0, 128'b0);
    rd("abort_status", 3'd3, 16'h0000);
    rd("abort_pcount", 3'd4, 16'd4);

    // ABORT and START together: no pulse
    wr(3'd1, 16'd0, 2'b11);
    wr(3'd0, 16'h000C, 2'b01);
    run("abst", 4, 128'b0, 128'b0, 128'b0);
    rd("abst_status", 3'd3, 16'h0000);
    rd("abst_pcount", 3'd4, 16'd4);

    // Any PCOUNT write clears it
    wr(3'd4, 16'h5555, 2'b10);
    rd("pc_clr", 3'd4, 16'h0000);

    // PCOUNT wrap from 0xFFFF
    force dut.pcount = 16'hFFFF;
    tick();
    release dut.pcount;
    rd("pc_preset", 3'd4, 16'hFFFF);
    wr(3'd2, 16'd1, 2'b11);
    wr(3'd0, 16'h0004, 2'b01);
    run("wrap", 3, 128'b001, 128'b0, 128'b0);
    rd("pc_wrap", 3'd4, 16'h0000);
    wr(3'd3, 16'h0002, 2'b01);

    // Byte-lane writes
    wr(3'd1, 16'h1234, 2'b11);
    wr(3'd1, 16'hAB00, 2'b10);
    rd("delay_hi", 3'd1, 16'hAB34);
    wr(3'd2, 16'hFF77, 2'b01);
    rd("width_lo", 3'd2, 16'h0077);

    // Unmapped offsets and out-of-window addresses
    rd("off5", 3'd5, 16'h0000);
    rd("off6", 3'd6, 16'h0000);
    rd("off7", 3'd7, 16'h0000);
    rd_addr("outside_hi", BASE + 14'd9, 16'h0000);
    rd_addr("outside_far", BASE ^ 14'h1001, 16'h0000);

    // Reset mid-pulse
    wr(3'd1, 16'd0, 2'b11);
    wr(3'd2, 16'd10, 2'b11);
    wr(3'd0, 16'h0007, 2'b01);
    run("rstmid", 3, 128'b111, 128'b0, 128'b0);
    puc_rst = 1'b1;
    tick();
    chk("rstmid_trig", {15'd0, trig_out}, 16'd0);
    puc_rst = 1'b0;
    for (int o = 0; o < 5; o++) rd($sformatf("rstmid_reg%0d", o), 3'(o), 16'h0000);
    run("rstmid_after", 12, 128'b0, 128'b0, 128'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
